house_sensor_frontend: RTL and testbench

- Producer side of the smart-house controller's request interface.
- Conditions raw sensor inputs into the controller's `isday`, `ring_req` and `temp_req` inputs:
  - doorbell button: synchroniser, debounce, one-shot pulse, lockout;
  - light level: day/night hysteresis FSM with dwell;
  - temperature: block average with clamping.
- Sits between the sensor pins/ADC and the controller, in the same clock domain as the controller.

---
 rtl/house_pkg.sv | 39 +++
 rtl/bell_debounce.sv | 70 +++++++
 rtl/house_sensor_frontend.sv | 171 +++++++++++++++++
 tb/tb_house_sensor_frontend.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/house_pkg.sv
// Shared types and default thresholds for the smart-house sensor front end and controller.
package house_pkg;

  typedef enum logic [1:0] {
    NIGHT    = 2'd0,
    TO_DAY   = 2'd1,
    DAY      = 2'd2,
    TO_NIGHT = 2'd3
  } day_state_t;

  localparam int TEMP_REQ_W          = 32;
  localparam int TEMP_SAMPLE_W       = 16;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_RING_LOCKOUT    = 16;
  localparam int DEF_LIGHT_W         = 10;
  localparam int DEF_DAY_ON_LEVEL    = 600;
  localparam int DEF_DAY_OFF_LEVEL   = 400;
  localparam int DEF_DAY_DWELL       = 3;
  localparam int DEF_TEMP_AVG_LOG2   = 2;
  localparam int DEF_TEMP_MIN        = -40;
  localparam int DEF_TEMP_MAX        = 85;
  localparam int DEF_TEMP_DEFAULT    = 25;

  function automatic logic signed [TEMP_REQ_W-1:0] clamp_temp(
    input logic signed [TEMP_REQ_W-1:0] value,
    input logic signed [TEMP_REQ_W-1:0] lo,
    input logic signed [TEMP_REQ_W-1:0] hi
  );
    if (value < lo) begin
      return lo;
    end else if (value > hi) begin
      return hi;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/bell_debounce.sv
// Doorbell conditioning: 2-flop synchroniser, debounce, one-shot ring pulse with lockout.
module bell_debounce
  import house_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RING_LOCKOUT    = DEF_RING_LOCKOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic bell_btn,
  output logic ring_req
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LCK_W  = $clog2(RING_LOCKOUT + 1);

  logic              sync1_r;
  logic              sync2_r;
  logic              deb_r;
  logic              deb_prev_r;
  logic [DCNT_W-1:0] cnt_r;
  logic [LCK_W-1:0]  lockout_r;
  logic              ring_req_r;

  // Synchronise the raw button and commit a new level once it has been stable long enough
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= bell_btn;
      sync2_r <= sync1_r;
      if (sync2_r == deb_r) begin
        cnt_r <= '0;
      end else if (cnt_r == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt_r <= '0;
        deb_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + DCNT_W'(1);
      end
    end
  end

  // Rising edge of the debounced level fires one pulse unless the lockout window is still open
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      deb_prev_r <= 1'b0;
      lockout_r  <= '0;
      ring_req_r <= 1'b0;
    end else begin
      deb_prev_r <= deb_r;
      if (deb_r && !deb_prev_r && (lockout_r == '0)) begin
        ring_req_r <= 1'b1;
        lockout_r  <= LCK_W'(RING_LOCKOUT);
      end else begin
        ring_req_r <= 1'b0;
        if (lockout_r != '0) begin
          lockout_r <= lockout_r - LCK_W'(1);
        end else begin
          lockout_r <= lockout_r;
        end
      end
    end
  end

  assign ring_req = ring_req_r;

endmodule

// File: rtl/house_sensor_frontend.sv
// Sensor front end for the house controller: bell pulse, day/night FSM, averaged temperature.
module house_sensor_frontend
  import house_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RING_LOCKOUT    = DEF_RING_LOCKOUT,
  parameter int LIGHT_W         = DEF_LIGHT_W,
  parameter int DAY_ON_LEVEL    = DEF_DAY_ON_LEVEL,
  parameter int DAY_OFF_LEVEL   = DEF_DAY_OFF_LEVEL,
  parameter int DAY_DWELL       = DEF_DAY_DWELL,
  parameter int TEMP_AVG_LOG2   = DEF_TEMP_AVG_LOG2,
  parameter int TEMP_MIN        = DEF_TEMP_MIN,
  parameter int TEMP_MAX        = DEF_TEMP_MAX,
  parameter int TEMP_DEFAULT    = DEF_TEMP_DEFAULT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            bell_btn,
  input  logic [LIGHT_W-1:0]              light_level,
  input  logic                            light_valid,
  input  logic signed [TEMP_SAMPLE_W-1:0] temp_sample,
  input  logic                            temp_valid,
  output logic                            isday,
  output logic                            ring_req,
  output logic signed [TEMP_REQ_W-1:0]    temp_req,
  output logic                            temp_update
);

  localparam int DW_W  = $clog2(DAY_DWELL + 1);
  localparam int ACC_W = TEMP_SAMPLE_W + TEMP_AVG_LOG2;
  localparam int TCNT_W = (TEMP_AVG_LOG2 > 0) ? TEMP_AVG_LOG2 : 1;

  day_state_t                   state_r;
  logic [DW_W-1:0]              dwell_r;
  logic                         isday_r;
  logic                         day_hi_s;
  logic                         day_lo_s;

  logic signed [ACC_W-1:0]      acc_r;
  logic [TCNT_W-1:0]            tcnt_r;
  logic signed [TEMP_REQ_W-1:0] temp_req_r;
  logic                         temp_update_r;
  logic signed [ACC_W-1:0]      sample_ext_s;
  logic signed [ACC_W-1:0]      sum_s;
  logic signed [ACC_W-1:0]      avg_s;
  logic signed [TEMP_REQ_W-1:0] avg_ext_s;
  logic signed [TEMP_REQ_W-1:0] clamped_s;

  bell_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RING_LOCKOUT    (RING_LOCKOUT)
  ) u_bell (
    .clock    (clock),
    .reset    (reset),
    .bell_btn (bell_btn),
    .ring_req (ring_req)
  );

  assign day_hi_s = (light_level >= LIGHT_W'(DAY_ON_LEVEL));
  assign day_lo_s = (light_level <  LIGHT_W'(DAY_OFF_LEVEL));

  // Day/night hysteresis: only valid samples advance the dwell count; isday tracks DAY/TO_NIGHT
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= NIGHT;
      dwell_r <= '0;
      isday_r <= 1'b0;
    end else if (light_valid) begin
      case (state_r)
        NIGHT: begin
          if (day_hi_s) begin
            if (DAY_DWELL == 1) begin
              state_r <= DAY;
              dwell_r <= '0;
              isday_r <= 1'b1;
            end else begin
              state_r <= TO_DAY;
              dwell_r <= DW_W'(1);
            end
          end else begin
            dwell_r <= '0;
          end
        end
        TO_DAY: begin
          if (!day_hi_s) begin
            state_r <= NIGHT;
            dwell_r <= '0;
          end else if (dwell_r == DW_W'(DAY_DWELL - 1)) begin
            state_r <= DAY;
            dwell_r <= '0;
            isday_r <= 1'b1;
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        DAY: begin
          if (day_lo_s) begin
            if (DAY_DWELL == 1) begin
              state_r <= NIGHT;
              dwell_r <= '0;
              isday_r <= 1'b0;
            end else begin
              state_r <= TO_NIGHT;
              dwell_r <= DW_W'(1);
            end
          end else begin
            dwell_r <= '0;
          end
        end
        TO_NIGHT: begin
          if (!day_lo_s) begin
            state_r <= DAY;
            dwell_r <= '0;
          end else if (dwell_r == DW_W'(DAY_DWELL - 1)) begin
            state_r <= NIGHT;
            dwell_r <= '0;
            isday_r <= 1'b0;
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
          end
        end
        default: begin
          state_r <= NIGHT;
          dwell_r <= '0;
          isday_r <= 1'b0;
        end
      endcase
    end else begin
      state_r <= state_r;
      dwell_r <= dwell_r;
      isday_r <= isday_r;
    end
  end

  // Block sum including the current sample, floored average, then clamped to the request range
  always_comb begin
    sample_ext_s = {{TEMP_AVG_LOG2{temp_sample[TEMP_SAMPLE_W-1]}}, temp_sample};
    sum_s        = acc_r + sample_ext_s;
    avg_s        = sum_s >>> TEMP_AVG_LOG2;
    avg_ext_s    = {{(TEMP_REQ_W - ACC_W){avg_s[ACC_W-1]}}, avg_s};
    clamped_s    = clamp_temp(avg_ext_s, TEMP_REQ_W'(TEMP_MIN), TEMP_REQ_W'(TEMP_MAX));
  end

  // Accumulate valid samples; the last sample of a block publishes the result and clears the block
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_r         <= '0;
      tcnt_r        <= '0;
      temp_req_r    <= TEMP_REQ_W'(TEMP_DEFAULT);
      temp_update_r <= 1'b0;
    end else if (temp_valid) begin
      if (tcnt_r == TCNT_W'((1 << TEMP_AVG_LOG2) - 1)) begin
        acc_r         <= '0;
        tcnt_r        <= '0;
        temp_req_r    <= clamped_s;
        temp_update_r <= 1'b1;
      end else begin
        acc_r         <= sum_s;
        tcnt_r        <= tcnt_r + TCNT_W'(1);
        temp_update_r <= 1'b0;
      end
    end else begin
      temp_update_r <= 1'b0;
    end
  end

  assign isday       = isday_r;
  assign temp_req    = temp_req_r;
  assign temp_update = temp_update_r;

endmodule

// File: tb/tb_house_sensor_frontend.sv
// Scoreboard bench for house_sensor_frontend: expectations queued at stimulus, checked at output.
module tb_house_sensor_frontend;

  localparam int NO_T = 99999;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               bell_btn = 1'b0;
  logic [9:0]         light_level = 10'd0;
  logic               light_valid = 1'b0;
  logic signed [15:0] temp_sample = 16'sd0;
  logic               temp_valid = 1'b0;
  logic               isday;
  logic               ring_req;
  logic signed [31:0] temp_req;
  logic               temp_update;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int ring_q[$];
  int temp_q[$];
  int day_q[$];

  always #5 clock = ~clock;

  house_sensor_frontend dut (
    .clock       (clock),
    .reset       (reset),
    .bell_btn    (bell_btn),
    .light_level (light_level),
    .light_valid (light_valid),
    .temp_sample (temp_sample),
    .temp_valid  (temp_valid),
    .isday       (isday),
    .ring_req    (ring_req),
    .temp_req    (temp_req),
    .temp_update (temp_update)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cycle counter: value seen after edge N is N
  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor, sampled shortly after each rising edge
  always @(posedge clock) begin
    #1;
    if (ring_req) begin
      if (ring_q.size() > 0) check_eq("ring_cycle", cyc, ring_q.pop_front());
      else check_eq("ring_unexpected", int'(ring_req), 0);
    end
    if (light_valid && reset) begin
      if (day_q.size() > 0) check_eq("isday", int'(isday), day_q.pop_front());
    end
    if (temp_update) begin
      if (temp_q.size() > 0) begin
        check_eq("temp_req", temp_req, temp_q.pop_front());
        check_eq("temp_upd_edge", int'(temp_valid), 1);
      end else begin
        check_eq("temp_unexpected", int'(temp_update), 0);
      end
    end
  end

  task automatic step(input logic b, input logic lv, input int ll, input int dexp,
                      input logic tv, input int ts, input int texp);
    @(negedge clock);
    bell_btn    = b;
    light_valid = lv;
    light_level = ll[9:0];
    temp_valid  = tv;
    temp_sample = ts[15:0];
    if (lv) day_q.push_back(dexp);
    if (tv && texp != NO_T) temp_q.push_back(texp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 0, NO_T);
  endtask

  task automatic press(input int hold, input bit expect_pulse);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, NO_T);
    if (expect_pulse) ring_q.push_back(cyc + 7);
    for (int i = 1; i < hold; i++) step(1'b1, 1'b0, 0, 0, 1'b0, 0, NO_T);
  endtask

  task automatic light(input int lvl, input int dexp);
    step(1'b0, 1'b1, lvl, dexp, 1'b0, 0, NO_T);
    idle(2);
  endtask

  task automatic temp_block(input int s0, input int s1, input int s2, input int s3, input int exp);
    step(1'b0, 1'b0, 0, 0, 1'b1, s0, NO_T);
    step(1'b0, 1'b0, 0, 0, 1'b1, s1, NO_T);
    idle(1);
    step(1'b0, 1'b0, 0, 0, 1'b1, s2, NO_T);
    step(1'b0, 1'b0, 0, 0, 1'b1, s3, exp);
    idle(3);
    check_eq("temp_hold", temp_req, exp);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Idle after reset
    for (int i = 0; i < 8; i++) begin
      idle(1);
      check_eq("rst_isday", int'(isday), 0);
      check_eq("rst_ring", int'(ring_req), 0);
      check_eq("rst_temp_req", temp_req, 25);
      check_eq("rst_temp_upd", int'(temp_update), 0);
    end

    // Bell: long hold, glitch, lockout window, clean second press
    press(20, 1'b1);
    idle(20);
    press(3, 1'b0);
    idle(20);
    press(5, 1'b1);
    idle(7);
    press(8, 1'b0);
    idle(17);
    press(5, 1'b1);
    idle(25);

    // Day/night hysteresis
    light(650, 0); light(650, 0); light(500, 0);
    light(650, 0); light(650, 0); light(650, 1);
    for (int i = 0; i < 10; i++) light(450, 1);
    light(300, 1); light(300, 1); light(300, 0);

    // Temperature averaging and clamping
    temp_block(30, 31, 32, 35, 32);
    temp_block(-3, -3, -3, -2, -3);
    temp_block(200, 200, 200, 200, 85);
    temp_block(-100, -100, -100, -100, -40);
    temp_block(-1, -1, -1, -2, -2);

    // All three paths in the same cycles
    step(1'b1, 1'b1, 650, 0, 1'b1, 20, NO_T);
    ring_q.push_back(cyc + 7);
    step(1'b1, 1'b1, 650, 0, 1'b1, 21, NO_T);
    step(1'b1, 1'b1, 650, 1, 1'b1, 22, NO_T);
    step(1'b1, 1'b0, 0, 0, 1'b1, 23, 21);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, NO_T);
    step(1'b1, 1'b0, 0, 0, 1'b0, 0, NO_T);
    idle(25);
    check_eq("conc_isday", int'(isday), 1);
    check_eq("conc_temp", temp_req, 21);

    // Reset in the middle of a temperature block
    step(1'b0, 1'b0, 0, 0, 1'b1, 50, NO_T);
    step(1'b0, 1'b0, 0, 0, 1'b1, 50, NO_T);
    @(negedge clock);
    temp_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    check_eq("mid_rst_temp", temp_req, 25);
    check_eq("mid_rst_isday", int'(isday), 0);
    check_eq("mid_rst_upd", int'(temp_update), 0);
    reset = 1'b1;
    idle(2);
    temp_block(10, 10, 10, 11, 10);

    idle(10);
    check_eq("ring_q_left", ring_q.size(), 0);
    check_eq("temp_q_left", temp_q.size(), 0);
    check_eq("day_q_left", day_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
